// File: rtl/dcm_sp_ctrl.sv
// ============================================================================
// Module   : dcm_sp_ctrl
// Purpose  : Reset/lock sequencer and variable phase-shift stepper for a
//            DCM_SP. Holds the DCM in reset, waits for LOCKED with a timeout,
//            retries on failure or lock loss, then walks PSEN/PSINCDEC one
//            step at a time toward a clamped signed phase target.
// Ports    : clk2x        - controller clock (also the DCM PSCLK)
//            resetb       - asynchronous active-low reset
//            dcm_rst      - DCM RST
//            dcm_locked   - DCM LOCKED (asynchronous, synchronized here)
//            psen         - DCM PSEN, single-cycle pulse
//            psincdec     - DCM PSINCDEC, 1 = increment
//            psdone       - DCM PSDONE (synchronous to clk2x)
//            ps_req       - phase request level, sampled in READY only
//            ps_target    - signed requested phase
//            ps_ack       - pulse when ps_value reaches the clamped target
//            ps_abort     - pulse when a request is dropped by a relock
//            ps_value     - signed currently applied phase
//            ready        - high in READY only
//            relock_count - reset attempts after the first, saturating
//            err_timeout  - sticky lock / psdone timeout flag
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dcm_sp_ctrl #(
    parameter int RST_HOLD_CYCLES = 8,
    parameter int LOCK_TIMEOUT    = 4096,
    parameter int PSDONE_TIMEOUT  = 1024,
    parameter int PS_MAX          = 255
) (
    input  logic       clk2x,
    input  logic       resetb,
    output logic       dcm_rst,
    input  logic       dcm_locked,
    output logic       psen,
    output logic       psincdec,
    input  logic       psdone,
    input  logic       ps_req,
    input  logic [8:0] ps_target,
    output logic       ps_ack,
    output logic       ps_abort,
    output logic [8:0] ps_value,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic       err_timeout
);

    localparam int c_cnt_max = (LOCK_TIMEOUT > PSDONE_TIMEOUT)
                             ? ((LOCK_TIMEOUT > RST_HOLD_CYCLES) ? LOCK_TIMEOUT : RST_HOLD_CYCLES)
                             : ((PSDONE_TIMEOUT > RST_HOLD_CYCLES) ? PSDONE_TIMEOUT : RST_HOLD_CYCLES);
    localparam int c_cnt_w = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(RST_HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_lock_last = c_cnt_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_psd_last  = c_cnt_w'(PSDONE_TIMEOUT - 1);

    localparam logic signed [8:0] c_ps_max = 9'(PS_MAX);
    localparam logic signed [8:0] c_ps_min = -9'(PS_MAX);

    typedef enum logic [2:0] {
        S_RST_HOLD  = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_READY     = 3'd2,
        S_PS_STEP   = 3'd3,
        S_PS_WAIT   = 3'd4,
        S_PS_ACK    = 3'd5
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_lock_meta;
    logic                 r_lock_sync;
    logic signed [8:0]    r_tgt;
    logic signed [8:0]    r_ps_value;
    logic                 r_dcm_rst;
    logic                 r_psen;
    logic                 r_psincdec;
    logic                 r_ps_ack;
    logic                 r_ps_abort;
    logic                 r_ready;
    logic [7:0]           r_relock;
    logic                 r_err;

    logic signed [8:0]    w_tgt_clamp;
    logic signed [8:0]    w_ps_next;
    logic                 w_psd_expire;
    logic                 w_relock;
    logic                 w_abort;
    logic                 w_err;

    always_comb begin
        w_tgt_clamp = $signed(ps_target);
        if ($signed(ps_target) > c_ps_max) begin
            w_tgt_clamp = c_ps_max;
        end else if ($signed(ps_target) < c_ps_min) begin
            w_tgt_clamp = c_ps_min;
        end
    end

    assign w_ps_next    = r_psincdec ? (r_ps_value + 9'sd1) : (r_ps_value - 9'sd1);
    assign w_psd_expire = !psdone && (r_cnt == c_psd_last);

    // Every path back to RST_HOLD is decided here so the state register
    // handles the common relock bookkeeping in one place.
    always_comb begin
        w_relock = 1'b0;
        case (r_state)
            S_WAIT_LOCK: w_relock = !r_lock_sync && (r_cnt == c_lock_last);
            S_READY,
            S_PS_STEP,
            S_PS_ACK:    w_relock = !r_lock_sync;
            S_PS_WAIT:   w_relock = !r_lock_sync || w_psd_expire;
            default:     w_relock = 1'b0;
        endcase
    end

    // An ack already in flight in PS_ACK is not turned into an abort.
    assign w_abort = w_relock && ((r_state == S_PS_STEP) || (r_state == S_PS_WAIT));
    assign w_err   = w_relock && ((r_state == S_WAIT_LOCK) ||
                                  ((r_state == S_PS_WAIT) && w_psd_expire));

    always_ff @(posedge clk2x or negedge resetb) begin
        if (!resetb) begin
            r_state     <= S_RST_HOLD;
            r_cnt       <= '0;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_tgt       <= '0;
            r_ps_value  <= '0;
            r_dcm_rst   <= 1'b1;
            r_psen      <= 1'b0;
            r_psincdec  <= 1'b0;
            r_ps_ack    <= 1'b0;
            r_ps_abort  <= 1'b0;
            r_ready     <= 1'b0;
            r_relock    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_lock_meta <= dcm_locked;
            r_lock_sync <= r_lock_meta;
            r_psen      <= 1'b0;
            r_ps_ack    <= 1'b0;
            r_ps_abort  <= 1'b0;
            r_cnt       <= r_cnt + 1'b1;

            case (r_state)
                S_RST_HOLD: begin
                    if (r_cnt == c_hold_last) begin
                        r_state   <= S_WAIT_LOCK;
                        r_dcm_rst <= 1'b0;
                        r_cnt     <= '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_lock_sync) begin
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_READY: begin
                    if (ps_req) begin
                        r_tgt   <= w_tgt_clamp;
                        r_ready <= 1'b0;
                        r_cnt   <= '0;
                        if (w_tgt_clamp == r_ps_value) begin
                            r_state  <= S_PS_ACK;
                            r_ps_ack <= 1'b1;
                        end else begin
                            r_state    <= S_PS_STEP;
                            r_psen     <= 1'b1;
                            r_psincdec <= (w_tgt_clamp > r_ps_value);
                        end
                    end
                end
                S_PS_STEP: begin
                    r_state <= S_PS_WAIT;
                    r_cnt   <= '0;
                end
                S_PS_WAIT: begin
                    if (psdone) begin
                        r_ps_value <= w_ps_next;
                        r_cnt      <= '0;
                        if (w_ps_next == r_tgt) begin
                            r_state  <= S_PS_ACK;
                            r_ps_ack <= 1'b1;
                        end else begin
                            r_state    <= S_PS_STEP;
                            r_psen     <= 1'b1;
                            r_psincdec <= (r_tgt > w_ps_next);
                        end
                    end
                end
                S_PS_ACK: begin
                    r_state <= S_READY;
                    r_ready <= 1'b1;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= S_RST_HOLD;
                    r_cnt   <= '0;
                end
            endcase

            // Relock overrides whatever the case branch scheduled; a DCM
            // reset discards the applied phase.
            if (w_relock) begin
                r_state    <= S_RST_HOLD;
                r_dcm_rst  <= 1'b1;
                r_cnt      <= '0;
                r_ps_value <= '0;
                r_psen     <= 1'b0;
                r_ps_ack   <= 1'b0;
                r_ready    <= 1'b0;
                r_ps_abort <= w_abort;
                if (r_relock != 8'hFF) begin
                    r_relock <= r_relock + 8'd1;
                end
            end
            if (w_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign dcm_rst      = r_dcm_rst;
    assign psen         = r_psen;
    assign psincdec     = r_psincdec;
    assign ps_ack       = r_ps_ack;
    assign ps_abort     = r_ps_abort;
    assign ps_value     = r_ps_value;
    assign ready        = r_ready;
    assign relock_count = r_relock;
    assign err_timeout  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dcm_sp_ctrl.sv
// ============================================================================
// Module   : tb_dcm_sp_ctrl
// Purpose  : Directed self-checking bench for dcm_sp_ctrl. Timeouts are
//            shortened (LOCK 64, PSDONE 40) so that relock saturation fits
//            in a short run; a PSDONE model answers 5 cycles after PSEN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dcm_sp_ctrl;

    localparam int RST_HOLD = 8;
    localparam int LOCK_TO  = 64;
    localparam int PSD_TO   = 40;
    localparam int PSD_LAT  = 5;

    logic       clk2x      = 1'b0;
    logic       resetb     = 1'b0;
    logic       dcm_locked = 1'b0;
    logic       psdone     = 1'b0;
    logic       ps_req     = 1'b0;
    logic [8:0] ps_target  = 9'd0;

    logic       dcm_rst, psen, psincdec, ps_ack, ps_abort, ready, err_timeout;
    logic [8:0] ps_value;
    logic [7:0] relock_count;

    int checks = 0;
    int errors = 0;

    // monitor state
    int  model_en    = 1;
    int  psd_cnt     = 0;
    int  psen_cnt    = 0;
    int  inc_cnt     = 0;
    int  dec_cnt     = 0;
    int  ack_cnt     = 0;
    int  abort_cnt   = 0;
    int  rst_run     = 0;
    int  low_run     = 0;
    int  last_rst_len = 0;
    int  last_low_len = 0;
    int  rst_pulses  = 0;
    int  nhist       = 0;
    int  minv        = 0;
    logic [8:0] prev_val = 9'd0;
    logic [8:0] hist [0:7];

    dcm_sp_ctrl #(
        .RST_HOLD_CYCLES (RST_HOLD),
        .LOCK_TIMEOUT    (LOCK_TO),
        .PSDONE_TIMEOUT  (PSD_TO),
        .PS_MAX          (255)
    ) dut (
        .clk2x        (clk2x),
        .resetb       (resetb),
        .dcm_rst      (dcm_rst),
        .dcm_locked   (dcm_locked),
        .psen         (psen),
        .psincdec     (psincdec),
        .psdone       (psdone),
        .ps_req       (ps_req),
        .ps_target    (ps_target),
        .ps_ack       (ps_ack),
        .ps_abort     (ps_abort),
        .ps_value     (ps_value),
        .ready        (ready),
        .relock_count (relock_count),
        .err_timeout  (err_timeout)
    );

    always #5 clk2x = ~clk2x;

    // PSDONE model plus event counters, all sampled on the falling edge.
    always @(negedge clk2x) begin
        psdone = 1'b0;
        if (psd_cnt > 0) begin
            psd_cnt = psd_cnt - 1;
            if (psd_cnt == 0) psdone = 1'b1;
        end
        if (psen === 1'b1) begin
            if (model_en != 0) psd_cnt = PSD_LAT;
            psen_cnt = psen_cnt + 1;
            if (psincdec === 1'b1) inc_cnt = inc_cnt + 1;
            else                   dec_cnt = dec_cnt + 1;
        end
        if (ps_ack === 1'b1)   ack_cnt = ack_cnt + 1;
        if (ps_abort === 1'b1) abort_cnt = abort_cnt + 1;
        if (dcm_rst === 1'b1) begin
            rst_run = rst_run + 1;
            if (low_run != 0) begin last_low_len = low_run; low_run = 0; end
        end else begin
            low_run = low_run + 1;
            if (rst_run != 0) begin
                last_rst_len = rst_run; rst_run = 0; rst_pulses = rst_pulses + 1;
            end
        end
        if (ps_value !== prev_val) begin
            if (nhist < 8) hist[nhist] = ps_value;
            nhist = nhist + 1;
            prev_val = ps_value;
        end
        if (int'($signed(ps_value)) < minv) minv = int'($signed(ps_value));
    end

    task automatic tick();
        @(negedge clk2x);
        #1;
    endtask

    task automatic clear_mon();
        psen_cnt = 0; inc_cnt = 0; dec_cnt = 0; ack_cnt = 0; abort_cnt = 0;
        rst_pulses = 0; nhist = 0; minv = 0;
    endtask

    // Called with the controller in RST_HOLD: let dcm_rst fall, lock 20
    // cycles later and wait for ready.
    task automatic relock_dcm(input string tag);
        int n;
        n = 0;
        while (dcm_rst === 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (dcm_rst !== 1'b0) begin
            errors++; $display("FAIL %s_rst_fall: dcm_rst=%b required 0", tag, dcm_rst);
        end
        repeat (20) tick();
        dcm_locked = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 10) begin tick(); n++; end
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL %s_ready: ready=%b required 1", tag, ready);
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0; dcm_locked = 1'b0;
        repeat (3) tick();
        checks++;
        if ({dcm_rst, psen, psincdec, ps_ack, ps_abort, ready, err_timeout} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl: {rst,psen,incdec,ack,abort,ready,err}=%b required 1000000",
                     {dcm_rst, psen, psincdec, ps_ack, ps_abort, ready, err_timeout});
        end
        checks++;
        if (ps_value !== 9'd0) begin
            errors++; $display("FAIL reset_ps_value: %0d required 0", ps_value);
        end
        checks++;
        if (relock_count !== 8'd0) begin
            errors++; $display("FAIL reset_relock: %0d required 0", relock_count);
        end
    endtask

    task automatic test_lock_up();
        int n;
        resetb = 1'b1;
        n = 0;
        while (dcm_rst === 1'b1 && n < 40) begin n++; tick(); end
        checks++;
        if (n != RST_HOLD) begin
            errors++; $display("FAIL lockup_rst_len: %0d cycles required %0d", n, RST_HOLD);
        end
        repeat (20) tick();
        dcm_locked = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 10) begin tick(); n++; end
        checks++;
        if (ready !== 1'b1 || n < 2 || n > 3) begin
            errors++; $display("FAIL lockup_ready: ready=%b after %0d cycles required 1 after 2..3", ready, n);
        end
        checks++;
        if (relock_count !== 8'd0 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL lockup_status: relock=%0d err=%b required 0/0", relock_count, err_timeout);
        end
    endtask

    task automatic test_ps_inc();
        int n;
        clear_mon();
        ps_target = 9'd3; ps_req = 1'b1;
        n = 0;
        while (ps_ack !== 1'b1 && n < 200) begin tick(); n++; end
        ps_req = 1'b0;
        checks++;
        if (ps_ack !== 1'b1 || ps_value !== 9'd3) begin
            errors++; $display("FAIL inc_ack: ack=%b value=%0d required 1/3", ps_ack, ps_value);
        end
        checks++;
        if (psen_cnt != 3 || inc_cnt != 3) begin
            errors++; $display("FAIL inc_psen: psen=%0d inc=%0d required 3/3", psen_cnt, inc_cnt);
        end
        checks++;
        if (nhist != 3 || hist[0] !== 9'd1 || hist[1] !== 9'd2 || hist[2] !== 9'd3) begin
            errors++; $display("FAIL inc_sequence: %0d changes (%0d,%0d,%0d) required 3 (1,2,3)",
                               nhist, hist[0], hist[1], hist[2]);
        end
        tick();
        checks++;
        if (ps_ack !== 1'b0 || ready !== 1'b1 || ack_cnt != 1) begin
            errors++; $display("FAIL inc_after_ack: ack=%b ready=%b acks=%0d required 0/1/1",
                               ps_ack, ready, ack_cnt);
        end
    endtask

    task automatic test_ps_clamp();
        int n;
        clear_mon();
        ps_target = 9'h100;            // -256: below -PS_MAX, clamps to -255
        ps_req = 1'b1;
        n = 0;
        while (ps_ack !== 1'b1 && n < 4000) begin tick(); n++; end
        ps_req = 1'b0;
        checks++;
        if (ps_ack !== 1'b1 || ps_value !== 9'h101) begin
            errors++; $display("FAIL clamp_ack: ack=%b value=%0d required 1/-255", ps_ack, $signed(ps_value));
        end
        checks++;
        if (psen_cnt != 258 || dec_cnt != 258 || inc_cnt != 0) begin
            errors++; $display("FAIL clamp_steps: psen=%0d dec=%0d inc=%0d required 258/258/0",
                               psen_cnt, dec_cnt, inc_cnt);
        end
        checks++;
        if (minv != -255) begin
            errors++; $display("FAIL clamp_min: %0d required -255", minv);
        end
        tick();
        clear_mon();
        ps_target = 9'h101; ps_req = 1'b1;
        n = 0;
        while (ps_ack !== 1'b1 && n < 10) begin tick(); n++; end
        ps_req = 1'b0;
        checks++;
        if (ps_ack !== 1'b1 || n != 1 || psen_cnt != 0) begin
            errors++; $display("FAIL same_target: ack=%b after %0d cycles psen=%0d required 1/1/0",
                               ps_ack, n, psen_cnt);
        end
        tick();
    endtask

    task automatic test_lock_loss_ready();
        int n;
        clear_mon();
        dcm_locked = 1'b0;
        n = 0;
        while (dcm_rst !== 1'b1 && n < 10) begin tick(); n++; end
        checks++;
        if (dcm_rst !== 1'b1 || ready !== 1'b0 || relock_count !== 8'd1 || ps_value !== 9'd0) begin
            errors++; $display("FAIL ready_lockloss: rst=%b ready=%b relock=%0d value=%0d required 1/0/1/0",
                               dcm_rst, ready, relock_count, ps_value);
        end
        relock_dcm("ready_lockloss");
        checks++;
        if (last_rst_len != RST_HOLD || rst_pulses != 1) begin
            errors++; $display("FAIL ready_lockloss_rst: len=%0d pulses=%0d required %0d/1",
                               last_rst_len, rst_pulses, RST_HOLD);
        end
    endtask

    task automatic test_lock_loss_ps();
        int n;
        int psen_snap;
        clear_mon();
        ps_target = 9'd5; ps_req = 1'b1;
        n = 0;
        while (ps_value !== 9'd2 && n < 200) begin tick(); n++; end
        n = 0;
        while (psen !== 1'b1 && n < 10) begin tick(); n++; end
        tick();                        // now in PS_WAIT for the third step
        dcm_locked = 1'b0;
        ps_req = 1'b0;
        n = 0;
        while (ps_abort !== 1'b1 && n < 10) begin tick(); n++; end
        checks++;
        if (ps_abort !== 1'b1 || ps_value !== 9'd0 || relock_count !== 8'd2) begin
            errors++; $display("FAIL ps_lockloss: abort=%b value=%0d relock=%0d required 1/0/2",
                               ps_abort, ps_value, relock_count);
        end
        tick();
        checks++;
        if (ps_abort !== 1'b0 || abort_cnt != 1 || ack_cnt != 0) begin
            errors++; $display("FAIL ps_lockloss_pulse: abort=%b aborts=%0d acks=%0d required 0/1/0",
                               ps_abort, abort_cnt, ack_cnt);
        end
        psen_snap = psen_cnt;
        relock_dcm("ps_lockloss");
        checks++;
        if (psen_cnt != psen_snap || ps_value !== 9'd0 || last_rst_len != RST_HOLD) begin
            errors++; $display("FAIL ps_lockloss_after: psen=%0d value=%0d rstlen=%0d required %0d/0/%0d",
                               psen_cnt, ps_value, last_rst_len, psen_snap, RST_HOLD);
        end
    endtask

    task automatic test_psdone_timeout();
        int n;
        clear_mon();
        model_en = 0;
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++; $display("FAIL psd_err_before: err=%b required 0", err_timeout);
        end
        ps_target = 9'd1; ps_req = 1'b1;
        n = 0;
        while (psen !== 1'b1 && n < 10) begin tick(); n++; end
        ps_req = 1'b0;
        n = 0;
        while (ps_abort !== 1'b1 && n < 200) begin tick(); n++; end
        checks++;
        if (ps_abort !== 1'b1 || n != PSD_TO + 1) begin
            errors++; $display("FAIL psd_timeout: abort=%b after %0d cycles required 1 after %0d",
                               ps_abort, n, PSD_TO + 1);
        end
        checks++;
        if (err_timeout !== 1'b1 || relock_count !== 8'd3 || dcm_rst !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL psd_status: err=%b relock=%0d rst=%b ready=%b required 1/3/1/0",
                               err_timeout, relock_count, dcm_rst, ready);
        end
        model_en = 1;
        relock_dcm("psd");
    endtask

    task automatic test_async_reset();
        tick();
        resetb = 1'b0;
        dcm_locked = 1'b0;
        #1;
        checks++;
        if (err_timeout !== 1'b0 || relock_count !== 8'd0 || ready !== 1'b0 || dcm_rst !== 1'b1) begin
            errors++; $display("FAIL async_reset: err=%b relock=%0d ready=%b rst=%b required 0/0/0/1",
                               err_timeout, relock_count, ready, dcm_rst);
        end
        repeat (2) tick();
    endtask

    task automatic test_lock_timeout();
        int n;
        int pulses;
        clear_mon();
        resetb = 1'b1;
        n = 0;
        while (relock_count === 8'd0 && n < 200) begin tick(); n++; end
        checks++;
        if (n != RST_HOLD + LOCK_TO || relock_count !== 8'd1 || err_timeout !== 1'b1) begin
            errors++; $display("FAIL lock_timeout_first: %0d cycles relock=%0d err=%b required %0d/1/1",
                               n, relock_count, err_timeout, RST_HOLD + LOCK_TO);
        end
        n = 0;
        while (relock_count !== 8'd255 && n < 30000) begin tick(); n++; end
        checks++;
        if (relock_count !== 8'd255) begin
            errors++; $display("FAIL lock_timeout_sat: relock=%0d required 255", relock_count);
        end
        checks++;
        if (last_rst_len != RST_HOLD || last_low_len != LOCK_TO) begin
            errors++; $display("FAIL lock_timeout_period: high=%0d low=%0d required %0d/%0d",
                               last_rst_len, last_low_len, RST_HOLD, LOCK_TO);
        end
        pulses = rst_pulses;
        repeat (3 * (RST_HOLD + LOCK_TO)) tick();
        checks++;
        if (relock_count !== 8'd255 || rst_pulses < pulses + 2) begin
            errors++; $display("FAIL lock_timeout_hold: relock=%0d new pulses=%0d required 255/>=2",
                               relock_count, rst_pulses - pulses);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock_up();
        test_ps_inc();
        test_ps_clamp();
        test_lock_loss_ready();
        test_lock_loss_ps();
        test_psdone_timeout();
        test_async_reset();
        test_lock_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
